// File: rtl/vga_tile_blit_seq.sv
// Tile blitter: resolves a map/HUD draw request to a screen origin and streams
// every on-screen pixel coordinate of the tile in raster order over valid/ready.
module vga_tile_blit_seq #(
    parameter int unsigned MAP_COLS    = 15,
    parameter int unsigned MAP_ROWS    = 15,
    parameter int unsigned TILE_PX     = 30,
    parameter int unsigned ORG_X       = 95,
    parameter int unsigned ORG_Y       = 15,
    parameter int unsigned PORT_PX     = 90,
    parameter int unsigned HEART_PX    = 20,
    parameter int unsigned HEART_PITCH = 24,
    parameter int unsigned SPR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_col,
    input  logic [4:0]       req_row,
    input  logic [SPR_W-1:0] req_sprite,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic [6:0]       pix_u,
    output logic [6:0]       pix_v,
    output logic [SPR_W-1:0] pix_sprite,
    output logic             pix_last,
    output logic             busy,
    output logic             err
);

    localparam int unsigned XW    = 10;
    localparam int unsigned UW    = 7;
    localparam int unsigned CW    = 5;
    localparam int unsigned AW    = 12;
    localparam int unsigned SCR_W = 640;
    localparam int unsigned SCR_H = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     row_q, row_d;
    logic [SPR_W-1:0]  spr_q, spr_d;
    logic [AW-1:0]     ox_q, ox_d;
    logic [AW-1:0]     oy_q, oy_d;
    logic [UW-1:0]     s_q, s_d;
    logic [UW-1:0]     ulast_q, ulast_d;
    logic [UW-1:0]     vlast_q, vlast_d;
    logic [UW-1:0]     u_q, u_d;
    logic [UW-1:0]     v_q, v_d;
    logic              req_ready_q, req_ready_d;
    logic              pix_valid_q, pix_valid_d;
    logic [XW-1:0]     pix_x_q, pix_x_d;
    logic [XW-1:0]     pix_y_q, pix_y_d;
    logic [UW-1:0]     pix_u_q, pix_u_d;
    logic [UW-1:0]     pix_v_q, pix_v_d;
    logic [SPR_W-1:0]  pix_sprite_q, pix_sprite_d;
    logic              pix_last_q, pix_last_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    // Setup-stage decode
    logic              is_map, is_hud;
    logic [1:0]        hud_p;
    logic [AW-1:0]     base_x, base_y;
    logic [AW-1:0]     set_ox, set_oy;
    logic [UW-1:0]     set_s, set_ulast, set_vlast;
    logic [AW-1:0]     rem_x, rem_y;

    // Emit-stage shared terms
    logic [AW-1:0]     cur_x, cur_y;
    logic              clipped, slot_free, last_acc, at_end, load;
    logic [UW-1:0]     s_m1;

    always_comb begin
        is_map = (AW'(col_q) < AW'(MAP_COLS)) && (AW'(row_q) < AW'(MAP_ROWS));
        is_hud = (AW'(col_q) >= AW'(MAP_COLS)) && (AW'(col_q) < AW'(MAP_COLS + 4))
                 && (row_q < CW'(4));
        hud_p  = 2'(col_q - CW'(MAP_COLS));
        case (hud_p)
            2'd0:    begin base_x = AW'(4);   base_y = AW'(121); end
            2'd1:    begin base_x = AW'(548); base_y = AW'(254); end
            2'd2:    begin base_x = AW'(4);   base_y = AW'(254); end
            default: begin base_x = AW'(548); base_y = AW'(121); end
        endcase
        if (is_map) begin
            set_ox = AW'(ORG_X) + AW'(TILE_PX) * AW'(col_q);
            set_oy = AW'(ORG_Y) + AW'(TILE_PX) * AW'(row_q);
            set_s  = UW'(TILE_PX);
        end else if (row_q == CW'(0)) begin
            set_ox = base_x;
            set_oy = base_y;
            set_s  = UW'(PORT_PX);
        end else begin
            set_ox = base_x + AW'(10) + AW'(HEART_PITCH) * (AW'(row_q) - AW'(1));
            set_oy = base_y + AW'(95);
            set_s  = UW'(HEART_PX);
        end
        // Last on-screen u/v; the raster walk still visits clipped pixels
        rem_x = AW'(SCR_W) - set_ox;
        rem_y = AW'(SCR_H) - set_oy;
        if (set_ox >= AW'(SCR_W))     set_ulast = '0;
        else if (rem_x < AW'(set_s))  set_ulast = UW'(rem_x - AW'(1));
        else                          set_ulast = set_s - UW'(1);
        if (set_oy >= AW'(SCR_H))     set_vlast = '0;
        else if (rem_y < AW'(set_s))  set_vlast = UW'(rem_y - AW'(1));
        else                          set_vlast = set_s - UW'(1);
    end

    always_comb begin
        s_m1      = s_q - UW'(1);
        cur_x     = ox_q + AW'(u_q);
        cur_y     = oy_q + AW'(v_q);
        clipped   = (cur_x >= AW'(SCR_W)) || (cur_y >= AW'(SCR_H));
        slot_free = !pix_valid_q || pix_ready;
        last_acc  = pix_valid_q && pix_ready && pix_last_q;
        at_end    = (u_q == s_m1) && (v_q == s_m1);
        load      = (state_q == EMIT) && slot_free && !last_acc;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            spr_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            s_q          <= '0;
            ulast_q      <= '0;
            vlast_q      <= '0;
            u_q          <= '0;
            v_q          <= '0;
            req_ready_q  <= 1'b1;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_u_q      <= '0;
            pix_v_q      <= '0;
            pix_sprite_q <= '0;
            pix_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            spr_q        <= spr_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            s_q          <= s_d;
            ulast_q      <= ulast_d;
            vlast_q      <= vlast_d;
            u_q          <= u_d;
            v_q          <= v_d;
            req_ready_q  <= req_ready_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_u_q      <= pix_u_d;
            pix_v_q      <= pix_v_d;
            pix_sprite_q <= pix_sprite_d;
            pix_last_q   <= pix_last_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) state_d = SETUP;
            end
            SETUP: begin
                state_d = (is_map || is_hud) ? EMIT : IDLE;
            end
            EMIT: begin
                if (last_acc)                       state_d = IDLE;
                else if (load && at_end && clipped) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        spr_d        = spr_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        s_d          = s_q;
        ulast_d      = ulast_q;
        vlast_d      = vlast_q;
        u_d          = u_q;
        v_d          = v_q;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_u_d      = pix_u_q;
        pix_v_d      = pix_v_q;
        pix_sprite_d = pix_sprite_q;
        pix_last_d   = pix_last_q;
        err_d        = 1'b0;
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    col_d = req_col;
                    row_d = req_row;
                    spr_d = req_sprite;
                end
            end
            SETUP: begin
                ox_d    = set_ox;
                oy_d    = set_oy;
                s_d     = set_s;
                ulast_d = set_ulast;
                vlast_d = set_vlast;
                u_d     = '0;
                v_d     = '0;
                err_d   = !(is_map || is_hud);
            end
            EMIT: begin
                if (last_acc) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                end else if (load) begin
                    pix_valid_d = !clipped;
                    pix_last_d  = !clipped && (u_q == ulast_q) && (v_q == vlast_q);
                    if (!clipped) begin
                        pix_x_d      = XW'(cur_x);
                        pix_y_d      = XW'(cur_y);
                        pix_u_d      = u_q;
                        pix_v_d      = v_q;
                        pix_sprite_d = spr_q;
                    end
                    if (u_q == s_m1) begin
                        u_d = '0;
                        v_d = v_q + UW'(1);
                    end else begin
                        u_d = u_q + UW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_u      = pix_u_q;
    assign pix_v      = pix_v_q;
    assign pix_sprite = pix_sprite_q;
    assign pix_last   = pix_last_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vga_tile_blit_seq.sv
// Directed bench for vga_tile_blit_seq: map/HUD tiles, backpressure, errors, reset abort.
module tb_vga_tile_blit_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_col;
    logic [4:0] req_row;
    logic [3:0] req_sprite;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [6:0] pix_u;
    logic [6:0] pix_v;
    logic [3:0] pix_sprite;
    logic       pix_last;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    vga_tile_blit_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_col(req_col), .req_row(req_row), .req_sprite(req_sprite),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_u(pix_u), .pix_v(pix_v),
        .pix_sprite(pix_sprite), .pix_last(pix_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Drive one request and return at the falling edge after the handshake edge.
    task automatic send_req(input logic [4:0] c, input logic [4:0] r, input logic [3:0] s);
        int n = 0;
        req_col = c; req_row = r; req_sprite = s; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL send_req: req_ready stuck at 0 for col=%0d row=%0d", c, r);
            $fatal(1);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Consume beats of one tile; tallies raster-order and stall-stability deviations.
    task automatic collect_tile(input int ox, input int oy, input int s, input bit bp,
                                output int beats, output int lasts, output int order_err,
                                output int stall_err, output int fx, output int fy,
                                output int lx, output int ly, output int lu, output int lv,
                                output int lspr, output bit last_flag, output bit timeout);
        logic [9:0] hx, hy;
        logic [6:0] hu, hv;
        logic [3:0] hs;
        logic       hl;
        bit held = 0;
        bit done = 0;
        int cyc  = 0;
        beats = 0; lasts = 0; order_err = 0; stall_err = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; lu = -1; lv = -1; lspr = -1; last_flag = 0;
        hx = '0; hy = '0; hu = '0; hv = '0; hs = '0; hl = 1'b0;
        while (!done && cyc < 40000) begin
            if (held && (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_u !== hu ||
                         pix_v !== hv || pix_sprite !== hs || pix_last !== hl))
                stall_err++;
            pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid === 1'b1) begin
                if (pix_ready) begin
                    if (int'(pix_x) != ox + beats % s || int'(pix_y) != oy + beats / s ||
                        int'(pix_u) != beats % s || int'(pix_v) != beats / s)
                        order_err++;
                    if (beats == 0) begin fx = int'(pix_x); fy = int'(pix_y); end
                    if (pix_last) lasts++;
                    lx = int'(pix_x); ly = int'(pix_y); lu = int'(pix_u); lv = int'(pix_v);
                    lspr = int'(pix_sprite); last_flag = pix_last;
                    beats++;
                    held = 0;
                    if (pix_last) done = 1;
                end else begin
                    held = 1;
                    hx = pix_x; hy = pix_y; hu = pix_u; hv = pix_v; hs = pix_sprite; hl = pix_last;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_col = '0; req_row = '0; req_sprite = '0;
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_tests++; if ({pix_valid, pix_last, busy, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {pix_valid, pix_last, busy, err}); end
        n_tests++; if ({pix_x, pix_y, pix_u, pix_v, pix_sprite} !== '0) begin n_fail++; $display("FAIL reset_data: got x=%0d y=%0d u=%0d v=%0d spr=%0d want 0", pix_x, pix_y, pix_u, pix_v, pix_sprite); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_map_origin();
        int b, l, oe, se, fx, fy, lx, ly, lu, lv, ls;
        bit lf, to;
        send_req(5'd0, 5'd0, 4'd3);
        n_tests++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL map00_busy: ready=%b busy=%b want 0/1", req_ready, busy); end
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL map00_lat1: pix_valid=%b want 0", pix_valid); end
        @(negedge clk);
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL map00_lat2: pix_valid=%b want 0", pix_valid); end
        @(negedge clk);
        n_tests++; if (pix_valid !== 1'b1 || pix_x !== 10'd95 || pix_y !== 10'd15 || pix_u !== 7'd0 || pix_v !== 7'd0) begin n_fail++; $display("FAIL map00_first: v=%b x=%0d y=%0d u=%0d v=%0d want 1 95 15 0 0", pix_valid, pix_x, pix_y, pix_u, pix_v); end
        collect_tile(95, 15, 30, 0, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        n_tests++; if (to || b != 900 || oe != 0) begin n_fail++; $display("FAIL map00_beats: beats=%0d order_err=%0d timeout=%b want 900 0 0", b, oe, to); end
        n_tests++; if (lx != 124 || ly != 44 || lu != 29 || lv != 29 || !lf || l != 1 || ls != 3) begin n_fail++; $display("FAIL map00_last: (%0d,%0d) u%0d v%0d last=%b n=%0d spr=%0d want (124,44) 29 29 1 1 3", lx, ly, lu, lv, lf, l, ls); end
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL map00_done: ready=%b valid=%b busy=%b want 1 0 0", req_ready, pix_valid, busy); end
    endtask

    task automatic test_map_corner();
        int b, l, oe, se, fx, fy, lx, ly, lu, lv, ls;
        bit lf, to;
        send_req(5'd14, 5'd14, 4'd9);
        collect_tile(515, 435, 30, 0, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        n_tests++; if (to || b != 900 || oe != 0 || fx != 515 || fy != 435) begin n_fail++; $display("FAIL map1414_beats: beats=%0d oe=%0d first=(%0d,%0d) want 900 0 (515,435)", b, oe, fx, fy); end
        n_tests++; if (lx != 544 || ly != 464 || !lf || l != 1 || ls != 9) begin n_fail++; $display("FAIL map1414_last: (%0d,%0d) last=%b n=%0d spr=%0d want (544,464) 1 1 9", lx, ly, lf, l, ls); end
        @(negedge clk);
    endtask

    task automatic test_hud();
        int b, l, oe, se, fx, fy, lx, ly, lu, lv, ls;
        bit lf, to;
        send_req(5'd15, 5'd0, 4'd5);
        collect_tile(4, 121, 90, 0, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        n_tests++; if (to || b != 8100 || oe != 0 || fx != 4 || fy != 121) begin n_fail++; $display("FAIL portrait_beats: beats=%0d oe=%0d first=(%0d,%0d) want 8100 0 (4,121)", b, oe, fx, fy); end
        n_tests++; if (lx != 93 || ly != 210 || lu != 89 || lv != 89 || !lf || l != 1) begin n_fail++; $display("FAIL portrait_last: (%0d,%0d) u%0d v%0d last=%b n=%0d want (93,210) 89 89 1 1", lx, ly, lu, lv, lf, l); end
        @(negedge clk);
        send_req(5'd16, 5'd2, 4'd1);
        collect_tile(582, 349, 20, 0, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        n_tests++; if (to || b != 400 || oe != 0 || fx != 582 || fy != 349) begin n_fail++; $display("FAIL heart_beats: beats=%0d oe=%0d first=(%0d,%0d) want 400 0 (582,349)", b, oe, fx, fy); end
        n_tests++; if (lx != 601 || ly != 368 || !lf || l != 1) begin n_fail++; $display("FAIL heart_last: (%0d,%0d) last=%b n=%0d want (601,368) 1 1", lx, ly, lf, l); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int b, l, oe, se, fx, fy, lx, ly, lu, lv, ls;
        bit lf, to;
        send_req(5'd7, 5'd3, 4'd12);
        collect_tile(305, 105, 30, 1, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        pix_ready = 1'b1;
        n_tests++; if (to || b != 900 || oe != 0) begin n_fail++; $display("FAIL bp_beats: beats=%0d order_err=%0d timeout=%b want 900 0 0", b, oe, to); end
        n_tests++; if (se != 0) begin n_fail++; $display("FAIL bp_stable: stall_changes=%0d want 0", se); end
        n_tests++; if (lx != 334 || ly != 134 || !lf || l != 1 || ls != 12) begin n_fail++; $display("FAIL bp_last: (%0d,%0d) last=%b n=%0d spr=%0d want (334,134) 1 1 12", lx, ly, lf, l, ls); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [4:0] cols [2];
        logic [4:0] rows [2];
        cols[0] = 5'd20; rows[0] = 5'd0;
        cols[1] = 5'd15; rows[1] = 5'd4;
        for (int i = 0; i < 2; i++) begin
            int errs = 0;
            int beats = 0;
            int ready_at = -1;
            send_req(cols[i], rows[i], 4'd2);
            for (int k = 0; k < 5; k++) begin
                if (err === 1'b1) errs++;
                if (pix_valid === 1'b1) beats++;
                if (ready_at < 0 && req_ready === 1'b1) ready_at = k;
                @(negedge clk);
            end
            n_tests++; if (errs != 1 || beats != 0) begin n_fail++; $display("FAIL err_pulse[%0d]: err_cycles=%0d beats=%0d want 1 0", i, errs, beats); end
            n_tests++; if (ready_at < 0 || ready_at > 1) begin n_fail++; $display("FAIL err_ready[%0d]: ready after %0d cycles want <=1", i, ready_at); end
        end
    endtask

    task automatic test_reset_mid();
        int b, l, oe, se, fx, fy, lx, ly, lu, lv, ls;
        bit lf, to;
        int cnt = 0;
        int cyc = 0;
        send_req(5'd2, 5'd2, 4'd6);
        while (cnt < 100 && cyc < 1000) begin
            if (pix_valid === 1'b1 && pix_ready) cnt++;
            if (cnt < 100) begin @(negedge clk); cyc++; end
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (pix_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || cnt != 100) begin n_fail++; $display("FAIL rst_abort: valid=%b busy=%b ready=%b beats=%0d want 0 0 1 100", pix_valid, busy, req_ready, cnt); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: pix_valid=%b want 0", pix_valid); end
        send_req(5'd1, 5'd1, 4'd4);
        collect_tile(125, 45, 30, 0, b, l, oe, se, fx, fy, lx, ly, lu, lv, ls, lf, to);
        n_tests++; if (to || b != 900 || oe != 0 || fx != 125 || fy != 45) begin n_fail++; $display("FAIL rst_restart: beats=%0d oe=%0d first=(%0d,%0d) want 900 0 (125,45)", b, oe, fx, fy); end
        n_tests++; if (lx != 154 || ly != 74 || !lf || l != 1 || ls != 4) begin n_fail++; $display("FAIL rst_restart_last: (%0d,%0d) last=%b n=%0d spr=%0d want (154,74) 1 1 4", lx, ly, lf, l, ls); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_map_origin();
        test_map_corner();
        test_hud();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
